// File: rtl/pattern_transmitter_pkg.sv
// Shared definitions for the pattern transmitter: FSM states, length default
// and the seven-segment digit codes used by the display side of the system.
package pattern_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } ptx_state_e;

  localparam int MAX_LEN_DEFAULT = 24;

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0     = 7'b011_1111;
  localparam logic [6:0] SEG_1     = 7'b000_0110;
  localparam logic [6:0] SEG_2     = 7'b101_1011;
  localparam logic [6:0] SEG_3     = 7'b100_1111;
  localparam logic [6:0] SEG_4     = 7'b110_0110;
  localparam logic [6:0] SEG_5     = 7'b110_1101;
  localparam logic [6:0] SEG_6     = 7'b111_1101;
  localparam logic [6:0] SEG_7     = 7'b000_0111;
  localparam logic [6:0] SEG_8     = 7'b111_1111;
  localparam logic [6:0] SEG_9     = 7'b110_1111;
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ptx_shift_reg.sv
// Parallel-load, serial-out shift register; MSB leaves first, holds when idle.
module ptx_shift_reg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift_en) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/pattern_transmitter.sv
// Serial pattern transmitter: captures a pattern/length pair and shifts it out
// MSB-first, optionally repeating the captured frame, counting finished frames.
module pattern_transmitter
  import pattern_transmitter_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic               repeat_mode,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  output logic               sig_out,
  output logic               busy,
  output logic               done,
  output logic [7:0]         frame_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  ptx_state_e         state_q, state_d;
  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] aligned;
  logic [MAX_LEN-1:0] cap_data_q;
  logic [LEN_W-1:0]   cap_len_q;
  logic [LEN_W-1:0]   bit_cnt_q;
  logic [MAX_LEN-1:0] load_data;
  logic [LEN_W-1:0]   load_len;
  logic               load;
  logic               shift_en;
  logic               frame_end;
  logic               sr_msb;

  // Left-align the live pattern so pattern[len-1] sits at the register MSB.
  assign eff_len = (length == '0 || length > MAX_LEN_L) ? MAX_LEN_L : length;
  assign aligned = pattern << (MAX_LEN_L - eff_len);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    load_data = aligned;
    load_len  = eff_len;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ena) begin
          shift_en = 1'b1;
          if (bit_cnt_q == LEN_W'(1)) begin
            frame_end = 1'b1;
            state_d   = FINISH;
          end
        end
      end
      FINISH: begin
        // Leaves unconditionally so done stays a single-cycle pulse.
        if (repeat_mode) begin
          load      = 1'b1;
          load_data = cap_data_q;
          load_len  = cap_len_q;
          state_d   = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cap_data_q  <= '0;
      cap_len_q   <= '0;
      bit_cnt_q   <= '0;
      done        <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state_q <= state_d;
      done    <= frame_end;
      if (state_q == IDLE && start) begin
        cap_data_q <= aligned;
        cap_len_q  <= eff_len;
      end
      if (load) begin
        bit_cnt_q <= load_len;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q - LEN_W'(1);
      end
      if (frame_end) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  ptx_shift_reg #(
    .WIDTH(MAX_LEN)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .load_data(load_data),
    .msb      (sr_msb)
  );

  assign busy    = (state_q == SEND);
  assign sig_out = busy & sr_msb;

endmodule

// File: tb/tb_pattern_transmitter.sv
// Scoreboard bench for pattern_transmitter: stimulus queues the expected serial
// stream per frame; a negedge monitor consumes it as the DUT transmits.
module tb_pattern_transmitter;

  localparam int MAX_LEN = 24;
  localparam int LEN_W   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ena = 1'b1;
  logic               start = 1'b0;
  logic               repeat_mode = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   length = '0;
  logic               sig_out;
  logic               busy;
  logic               done;
  logic [7:0]         frame_count;

  typedef struct {
    bit       is_done;
    bit       b;
    bit [7:0] cnt;
  } exp_t;

  exp_t     exp_q[$];
  int       total = 0;
  int       bad = 0;
  bit [7:0] model_count = 8'd0;

  pattern_transmitter #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .repeat_mode(repeat_mode),
    .pattern    (pattern),
    .length     (length),
    .sig_out    (sig_out),
    .busy       (busy),
    .done       (done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected frame: the effective-length bits of pat from MSB down, then done.
  task automatic push_frame(input logic [MAX_LEN-1:0] pat, input int eff);
    exp_t e;
    for (int i = eff - 1; i >= 0; i--) begin
      e.is_done = 1'b0;
      e.b       = pat[i];
      e.cnt     = 8'd0;
      exp_q.push_back(e);
    end
    model_count = model_count + 8'd1;
    e.is_done = 1'b1;
    e.b       = 1'b0;
    e.cnt     = model_count;
    exp_q.push_back(e);
  endtask

  // Monitor: one sample per cycle, half a period away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("done_position", {31'd0, e.is_done}, 32'd1);
          check("done_sig_out", {31'd0, sig_out}, 32'd0);
          if (e.is_done) check("frame_count", {24'd0, frame_count}, {24'd0, e.cnt});
        end
      end else if (busy) begin
        if (exp_q.size() == 0) begin
          fail_now("busy_unexpected");
        end else begin
          e = exp_q[0];
          check("bit_position", {31'd0, e.is_done}, 32'd0);
          check("sig_out_bit", {31'd0, sig_out}, {31'd0, e.b});
          if (ena || e.is_done) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_sig_out", {31'd0, sig_out}, 32'd0);
      end
    end
  end

  // One start pulse, nframes expected frames; junk start/pattern/length are
  // applied while the frame runs to show that only the captured copy is used.
  task automatic run(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                     input bit rep, input int nframes, input bit rand_ena);
    int eff;
    int budget;
    eff = (len == 0 || int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
    @(posedge clk); #1;
    pattern     = pat;
    length      = len;
    repeat_mode = rep;
    ena         = 1'b1;
    start       = 1'b1;
    for (int f = 0; f < nframes; f++) push_frame(pat, eff);
    budget = nframes * (eff + 1) * 6 + 50;
    while (1) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
      if (exp_q.size() <= eff + 1) repeat_mode = 1'b0;
      start   = ($urandom_range(0, 5) == 0);
      pattern = MAX_LEN'($urandom);
      length  = LEN_W'($urandom);
      ena     = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
      budget--;
      if (budget == 0) begin
        fail_now("frame_timeout");
        exp_q.delete();
        break;
      end
    end
    start       = 1'b0;
    ena         = 1'b1;
    repeat_mode = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("rst_sig_out", {31'd0, sig_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_frame_count", {24'd0, frame_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Abort mid-frame: asynchronous reset clears outputs before any edge.
    @(posedge clk); #1;
    pattern = 24'h131753;
    length  = 5'd24;
    start   = 1'b1;
    push_frame(24'h131753, 24);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("abort_sig_out", {31'd0, sig_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    model_count = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort_count", {24'd0, frame_count}, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);

    run(24'h131753, 5'd24, 1'b0, 1, 1'b0);
    run(24'h131753, 5'd24, 1'b0, 1, 1'b1);
    run(24'hFFFFFF, 5'd0, 1'b0, 1, 1'b0);
    run(24'hABCDEF, 5'd31, 1'b0, 1, 1'b1);
    run(24'h000001, 5'd1, 1'b0, 1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      run(MAX_LEN'($urandom), LEN_W'($urandom), 1'b0, 1, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    run(24'h000005, 5'd4, 1'b1, 260, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run(MAX_LEN'($urandom), LEN_W'($urandom_range(1, 12)), 1'b1, 5, 1'b1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("final_frame_count", {24'd0, frame_count}, {24'd0, model_count});
    check("final_busy", {31'd0, busy}, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
